// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder
// Registered priority encoder for active-low interrupt request lines. Falling
// edges on N_I are synchronized and captured into a pending set. The highest
// pending index is presented on A with a VALID/ACK handshake. N_EI/N_EO/N_GS
// allow cascading in the style of a 74148.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   N_I    in   WIDTH  active-low request lines, asynchronous to clk
//   N_EI   in   1      active-low enable; high blocks new grants
//   ACK    in   1      consumer accepts the presented code
//   A      out  CW     granted index (registered); N_I[WIDTH-1] is highest priority
//   VALID  out  1      A holds a granted, unacknowledged request (registered)
//   N_GS   out  1      low when enabled and something is pending (combinational)
//   N_EO   out  1      low when enabled and nothing is pending (combinational)
module irq_priority_encoder #(
   parameter  int unsigned WIDTH       = 8,
   parameter  int unsigned SYNC_STAGES = 2,
   localparam int unsigned CW          = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] N_I,
   input  logic             N_EI,
   input  logic             ACK,
   output logic [CW-1:0]    A,
   output logic             VALID,
   output logic             N_GS,
   output logic             N_EO
);

   // Edges after reset release before edge capture is trusted.
   localparam int unsigned WARM = SYNC_STAGES + 1;
   localparam int unsigned WW   = $clog2(WARM + 1);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] fall_c;
   logic [WIDTH-1:0] pending_q;
   logic [WIDTH-1:0] pending_d;
   logic [WIDTH-1:0] ack_clr;
   logic [WW-1:0]    warm_q;
   logic             armed;
   logic [CW-1:0]    idx;
   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    a_d;
   logic             valid_d;

   // Request synchronizer and one-cycle-delayed copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '1;
         prev_q <= '1;
      end else begin
         sync_q[0] <= N_I;
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
         prev_q <= s;
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Sync/prev reset to idle-high, so a line already low at release would look
   // like a fresh fall; capture stays disarmed until the pipeline holds real samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         warm_q <= '0;
      end else if (warm_q != WW'(WARM)) begin
         warm_q <= warm_q + WW'(1);
      end
   end

   assign armed  = (warm_q == WW'(WARM));
   assign fall_c = prev_q & ~s & {WIDTH{armed}};

   // Highest set pending bit; ascending scan lets the top bit win.
   always_comb begin
      idx = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (pending_q[i]) idx = CW'(i);
      end
   end

   // Next state, presented code and pending update.
   always_comb begin
      state_d = state_q;
      a_d     = A;
      valid_d = VALID;
      ack_clr = '0;
      unique case (state_q)
         IDLE: begin
            if (!N_EI && (pending_q != '0)) begin
               a_d     = idx;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (ACK) begin
               ack_clr[A] = 1'b1;
               valid_d    = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A new edge on the acknowledged bit re-arms it: set wins over clear.
      pending_d = (pending_q & ~ack_clr) | fall_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         A         <= '0;
         VALID     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         A         <= a_d;
         VALID     <= valid_d;
      end
   end

   // Cascade status from enable and registered pending only.
   assign N_GS = ~(~N_EI & (pending_q != '0));
   assign N_EO = ~(~N_EI & (pending_q == '0));

endmodule
